// File: rtl/hash_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : hash_pkg
//  Description : Shared types and helpers for the hash stream packer.
//                FSM state encoding, default widths for SNTRUP757 and the
//                output word count helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package hash_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // SNTRUP757 defaults
    localparam int unsigned SNTRUP_P    = 757;
    localparam int unsigned DEF_COEF_W  = 13;
    localparam int unsigned DEF_ADDR_W  = 11;
    localparam int unsigned DEF_OUT_W   = 8;
    localparam int unsigned DEF_MEM_LAT = 1;

    // Number of OUT_W-bit words needed to carry cnt coefficients of coef_w bits.
    function automatic int unsigned words_for(input int unsigned cnt,
                                              input int unsigned coef_w,
                                              input int unsigned out_w);
        return (cnt * coef_w + out_w - 1) / out_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bit_accumulator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : bit_accumulator
//  Description : Little-endian bit accumulator. Inserts a COEF_W-bit value at
//                the current fill level and pops OUT_W bits from the bottom.
//                A same-cycle pop is applied before the insert.
//  Ports       : clk, rst_n     - clock, async active-low reset
//                clear          - synchronous empty
//                pop            - drop the low OUT_W bits
//                insert, din    - append din above the valid bits
//                dout           - low OUT_W bits of the accumulator
//                bits           - number of valid bits held
//  Revision    : 1.0 - initial release
// ============================================================================
module bit_accumulator
    import hash_pkg::*;
#(
    parameter  int unsigned COEF_W = DEF_COEF_W,
    parameter  int unsigned OUT_W  = DEF_OUT_W,
    localparam int unsigned ACC_W  = OUT_W + COEF_W - 1,
    localparam int unsigned CNT_W  = $clog2(ACC_W + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              pop,
    input  logic              insert,
    input  logic [COEF_W-1:0] din,
    output logic [OUT_W-1:0]  dout,
    output logic [CNT_W-1:0]  bits
);

    localparam logic [CNT_W-1:0] c_OUT_BITS  = CNT_W'(OUT_W);
    localparam logic [CNT_W-1:0] c_COEF_BITS = CNT_W'(COEF_W);

    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] w_acc_pop;
    logic [ACC_W-1:0] w_acc_next;
    logic [CNT_W-1:0] r_bits;
    logic [CNT_W-1:0] w_bits_pop;
    logic [CNT_W-1:0] w_bits_next;

    always_comb begin
        w_acc_pop  = r_acc;
        w_bits_pop = r_bits;
        if (pop) begin
            w_acc_pop  = r_acc >> OUT_W;
            w_bits_pop = r_bits - c_OUT_BITS;
        end
        w_acc_next  = w_acc_pop;
        w_bits_next = w_bits_pop;
        // Upper bits are always zero, so OR-ing places din without masking.
        if (insert) begin
            w_acc_next  = w_acc_pop | (ACC_W'(din) << w_bits_pop);
            w_bits_next = w_bits_pop + c_COEF_BITS;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc  <= '0;
            r_bits <= '0;
        end else if (clear) begin
            r_acc  <= '0;
            r_bits <= '0;
        end else begin
            r_acc  <= w_acc_next;
            r_bits <= w_bits_next;
        end
    end

    assign dout = r_acc[OUT_W-1:0];
    assign bits = r_bits;

endmodule
`default_nettype wire

// File: rtl/hash_stream_packer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : hash_stream_packer
//  Description : Reads count coefficients from a RAM, packs them little-endian
//                into a bitstream and streams it as OUT_W-bit words over a
//                valid/ready handshake.
//  Ports       : clk, rst_n              - clock, async active-low reset
//                start, count            - run request and coefficient count
//                mem_rd_en, mem_addr     - RAM read strobe and address
//                mem_rdata               - RAM data, MEM_LAT cycles after read
//                out_data/valid/ready    - packed word stream
//                out_last                - final word marker
//                busy, done              - run status, completion pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module hash_stream_packer
    import hash_pkg::*;
#(
    parameter int unsigned COEF_W  = DEF_COEF_W,
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned OUT_W   = DEF_OUT_W,
    parameter int unsigned MEM_LAT = DEF_MEM_LAT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] count,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [COEF_W-1:0] mem_rdata,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam int unsigned ACC_W  = OUT_W + COEF_W - 1;
    localparam int unsigned CNT_W  = $clog2(ACC_W + 1);
    // Wide enough for count * COEF_W bits expressed in words.
    localparam int unsigned WCNT_W = ADDR_W + $clog2(COEF_W);
    localparam logic [CNT_W-1:0] c_OUT_BITS = CNT_W'(OUT_W);

    state_t              r_state;
    state_t              w_state_n;
    logic [ADDR_W-1:0]   r_count;
    logic [ADDR_W-1:0]   r_index;
    logic [ADDR_W-1:0]   r_addr;
    logic [MEM_LAT-1:0]  r_pend;
    logic [WCNT_W-1:0]   r_words_left;
    logic [WCNT_W-1:0]   w_words;
    logic                w_inflight;
    logic                w_ret;
    logic                w_issue;
    logic                w_clear;
    logic                w_acc_pop;
    logic [CNT_W-1:0]    w_bits;

    assign w_words    = WCNT_W'(words_for(32'(count), COEF_W, OUT_W));
    assign w_inflight = |r_pend;
    assign w_ret      = r_pend[MEM_LAT-1];

    // One outstanding read; only refill once the accumulator cannot form a word.
    assign w_issue = (r_state == ST_RUN) && (r_index < r_count) &&
                     !w_inflight && (w_bits < c_OUT_BITS);

    assign mem_rd_en = w_issue;
    assign mem_addr  = w_issue ? r_index : r_addr;
    assign busy      = (r_state == ST_RUN) || (r_state == ST_FLUSH);
    assign done      = (r_state == ST_DONE);
    assign w_acc_pop = (r_state == ST_RUN) && out_valid && out_ready;

    bit_accumulator #(
        .COEF_W (COEF_W),
        .OUT_W  (OUT_W)
    ) u_acc (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (w_clear),
        .pop    (w_acc_pop),
        .insert (w_ret),
        .din    (mem_rdata),
        .dout   (out_data),
        .bits   (w_bits)
    );

    always_comb begin
        w_state_n = r_state;
        out_valid = 1'b0;
        out_last  = 1'b0;
        w_clear   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_clear = 1'b1;
                if (start) begin
                    w_state_n = (count != '0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                out_valid = (w_bits >= c_OUT_BITS);
                // Only reachable as a full word when the stream length is a
                // multiple of OUT_W; partial tails leave through FLUSH.
                out_last  = out_valid && (r_words_left == WCNT_W'(1));
                if (out_valid && out_ready && out_last) begin
                    w_state_n = ST_DONE;
                end else if ((r_index == r_count) && !w_inflight &&
                             (w_bits < c_OUT_BITS)) begin
                    w_state_n = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (w_bits == '0) begin
                    w_state_n = ST_DONE;
                end else begin
                    out_valid = 1'b1;
                    out_last  = 1'b1;
                    if (out_ready) begin
                        w_state_n = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                w_clear   = 1'b1;
                w_state_n = ST_IDLE;
            end
            default: w_state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_count      <= '0;
            r_index      <= '0;
            r_addr       <= '0;
            r_pend       <= '0;
            r_words_left <= '0;
        end else begin
            r_state <= w_state_n;
            r_pend  <= (r_pend << 1) | MEM_LAT'(w_issue);
            if ((r_state == ST_IDLE) && start) begin
                r_count      <= count;
                r_index      <= '0;
                r_words_left <= w_words;
            end else begin
                if (w_issue) begin
                    r_index <= r_index + ADDR_W'(1);
                    r_addr  <= r_index;
                end
                if (out_valid && out_ready) begin
                    r_words_left <= r_words_left - WCNT_W'(1);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hash_stream_packer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_hash_stream_packer
//  Description : Self-checking bench. Two packers (MEM_LAT 1 and 3) share
//                stimulus; one is selected per run. A bit-level golden packer
//                fills a scoreboard queue, a monitor pops it on each accepted
//                word and checks read addresses and stall stability.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hash_stream_packer;
    import hash_pkg::*;

    localparam int COEF_W = 13;
    localparam int ADDR_W = 11;
    localparam int OUT_W  = 8;
    localparam int LIMIT  = 20000;

    typedef struct packed {
        logic [OUT_W-1:0] data;
        logic             last;
    } exp_t;

    typedef struct {
        int cnt;
        bit lat3;
        bit rnd;
        int fill;      // 0 random, 1 {1ABC}, 2 {1FFF,0}, 3 ramp
        int exp_words;
        int exp_w0;    // -1 = not checked
        int exp_w1;
        bit poke;      // pulse start while busy
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic              start;
    logic [ADDR_W-1:0] count;
    logic              out_ready;
    logic              sel;
    logic              rnd_ready;
    int                cyc;

    logic              rd_a, rd_b, valid_a, valid_b, last_a, last_b;
    logic              busy_a, busy_b, done_a, done_b;
    logic [ADDR_W-1:0] addr_a, addr_b;
    logic [COEF_W-1:0] rdata_a;
    logic [COEF_W-1:0] pb [3];
    logic [OUT_W-1:0]  data_a, data_b;

    logic              m_rd, m_valid, m_last, m_busy, m_done;
    logic [ADDR_W-1:0] m_addr;
    logic [OUT_W-1:0]  m_data;

    logic [COEF_W-1:0] mem [0:2047];

    exp_t sb_q[$];
    int   addr_q[$];
    int   checks = 0;
    int   errors = 0;
    int   words_seen;
    int   last_acc_cyc;
    int   first_w [2];
    bit   prev_stall;
    exp_t prev_word;

    hash_stream_packer #(.COEF_W(COEF_W), .ADDR_W(ADDR_W), .OUT_W(OUT_W), .MEM_LAT(1)) u_dut_lat1 (
        .clk(clk), .rst_n(rst_n), .start(start && !sel), .count(count),
        .mem_rd_en(rd_a), .mem_addr(addr_a), .mem_rdata(rdata_a),
        .out_data(data_a), .out_valid(valid_a), .out_ready(out_ready),
        .out_last(last_a), .busy(busy_a), .done(done_a)
    );

    hash_stream_packer #(.COEF_W(COEF_W), .ADDR_W(ADDR_W), .OUT_W(OUT_W), .MEM_LAT(3)) u_dut_lat3 (
        .clk(clk), .rst_n(rst_n), .start(start && sel), .count(count),
        .mem_rd_en(rd_b), .mem_addr(addr_b), .mem_rdata(pb[2]),
        .out_data(data_b), .out_valid(valid_b), .out_ready(out_ready),
        .out_last(last_b), .busy(busy_b), .done(done_b)
    );

    // RAM models: data appears exactly MEM_LAT cycles after the read, zero otherwise.
    always @(posedge clk) begin
        rdata_a <= rd_a ? mem[addr_a] : '0;
        pb[0]   <= rd_b ? mem[addr_b] : '0;
        pb[1]   <= pb[0];
        pb[2]   <= pb[1];
        cyc     <= cyc + 1;
    end

    assign m_rd    = sel ? rd_b    : rd_a;
    assign m_addr  = sel ? addr_b  : addr_a;
    assign m_data  = sel ? data_b  : data_a;
    assign m_valid = sel ? valid_b : valid_a;
    assign m_last  = sel ? last_b  : last_a;
    assign m_busy  = sel ? busy_b  : busy_a;
    assign m_done  = sel ? done_b  : done_a;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: read addresses, accepted words, stall stability.
    always @(negedge clk) begin
        if (rst_n) begin
            if (m_rd) begin
                if (addr_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL extra_read actual=%0h expected=none", m_addr);
                end else begin
                    chk("read_addr", 32'(m_addr), 32'(addr_q.pop_front()));
                end
            end
            if (prev_stall) begin
                chk("stall_valid", 32'(m_valid), 32'd1);
                chk("stall_data", {23'd0, m_data, m_last}, {23'd0, prev_word});
            end
            prev_stall = m_valid && !out_ready;
            prev_word  = {m_data, m_last};
            if (m_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL extra_word actual=%0h expected=none", m_data);
                end else begin
                    chk("word", {23'd0, m_data, m_last}, {23'd0, sb_q.pop_front()});
                end
                if (words_seen < 2) first_w[words_seen] = int'(m_data);
                words_seen++;
                last_acc_cyc = cyc;
            end
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1 out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic push_golden(input int n);
        int total_bits;
        int nwords;
        total_bits = n * COEF_W;
        nwords     = (total_bits + OUT_W - 1) / OUT_W;
        for (int k = 0; k < nwords; k++) begin
            exp_t e;
            e.data = '0;
            for (int j = 0; j < OUT_W; j++) begin
                int s;
                s = k * OUT_W + j;
                if (s < total_bits) e.data[j] = mem[s / COEF_W][s % COEF_W];
            end
            e.last = (k == nwords - 1);
            sb_q.push_back(e);
        end
        for (int i = 0; i < n; i++) addr_q.push_back(i);
    endtask

    task automatic setup_and_start(input vec_t v);
        for (int i = 0; i < 2048; i++) begin
            case (v.fill)
                1:       mem[i] = (i == 0) ? 13'h1ABC : 13'h0555;
                2:       mem[i] = (i == 0) ? 13'h1FFF : 13'h0000;
                3:       mem[i] = 13'(i * 1234 + 77);
                default: mem[i] = 13'($urandom_range(0, 8191));
            endcase
        end
        sb_q.delete();
        addr_q.delete();
        words_seen = 0;
        first_w[0] = -1;
        first_w[1] = -1;
        push_golden(v.cnt);
        @(posedge clk);
        #1;
        sel       = v.lat3;
        rnd_ready = v.rnd;
        count     = ADDR_W'(v.cnt);
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        count = ADDR_W'(5);
    endtask

    task automatic wait_done(input vec_t v);
        int n;
        @(negedge clk);
        if (v.cnt == 0) chk("zero_done", 32'(m_done), 32'd1);
        else            chk("busy_after_start", 32'(m_busy), 32'd1);
        n = 0;
        while (!m_done && n < LIMIT) begin
            @(negedge clk);
            n++;
            if (v.poke && n == 40) begin
                start = 1'b1;
                count = ADDR_W'(2);
            end
            if (v.poke && n == 41) start = 1'b0;
        end
        if (n >= LIMIT) begin
            checks++; errors++;
            $display("FAIL done_timeout actual=%0d expected=<%0d", n, LIMIT);
        end else begin
            chk("words", 32'(words_seen), 32'(v.exp_words));
            chk("sb_left", 32'(sb_q.size()), 32'd0);
            chk("reads_left", 32'(addr_q.size()), 32'd0);
            chk("busy_in_done", 32'(m_busy), 32'd0);
            if (v.cnt != 0) chk("done_latency", 32'(cyc - last_acc_cyc), 32'd1);
            if (v.exp_w0 >= 0) chk("word0", 32'(first_w[0]), 32'(v.exp_w0));
            if (v.exp_w1 >= 0) chk("word1", 32'(first_w[1]), 32'(v.exp_w1));
            @(negedge clk);
            chk("done_one_cycle", 32'(m_done), 32'd0);
        end
    endtask

    vec_t vecs [7];

    initial begin
        vec_t rv;
        int   n;
        vecs[0] = '{cnt: 1,   lat3: 0, rnd: 0, fill: 1, exp_words: 2,    exp_w0: 'hBC, exp_w1: 'h1A, poke: 0};
        vecs[1] = '{cnt: 2,   lat3: 1, rnd: 0, fill: 2, exp_words: 4,    exp_w0: 'hFF, exp_w1: 'h1F, poke: 0};
        vecs[2] = '{cnt: 0,   lat3: 0, rnd: 0, fill: 0, exp_words: 0,    exp_w0: -1,   exp_w1: -1,   poke: 0};
        vecs[3] = '{cnt: 8,   lat3: 0, rnd: 1, fill: 3, exp_words: 13,   exp_w0: -1,   exp_w1: -1,   poke: 0};
        vecs[4] = '{cnt: 757, lat3: 0, rnd: 1, fill: 0, exp_words: 1231, exp_w0: -1,   exp_w1: -1,   poke: 1};
        vecs[5] = '{cnt: 757, lat3: 1, rnd: 1, fill: 0, exp_words: 1231, exp_w0: -1,   exp_w1: -1,   poke: 1};
        vecs[6] = '{cnt: 1,   lat3: 1, rnd: 1, fill: 1, exp_words: 2,    exp_w0: 'hBC, exp_w1: 'h1A, poke: 0};

        rst_n      = 1'b0;
        start      = 1'b0;
        count      = '0;
        sel        = 1'b0;
        rnd_ready  = 1'b0;
        cyc        = 0;
        prev_stall = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(m_valid), 32'd0);
        chk("rst_rd", 32'(m_rd), 32'd0);
        chk("rst_busy_done", {30'd0, m_busy, m_done}, 32'd0);
        chk("rst_data", {13'd0, m_data, m_addr}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            setup_and_start(vecs[i]);
            wait_done(vecs[i]);
        end

        // Abort a long run after word 100 with an asynchronous reset.
        rv = '{cnt: 757, lat3: 0, rnd: 0, fill: 0, exp_words: 1231, exp_w0: -1, exp_w1: -1, poke: 0};
        setup_and_start(rv);
        n = 0;
        while (words_seen < 100 && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        chk("reached_word100", 32'(words_seen), 32'd100);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_valid_last", {30'd0, m_valid, m_last}, 32'd0);
        chk("abort_rd_addr", {20'd0, m_rd, m_addr}, 32'd0);
        chk("abort_busy_done", {30'd0, m_busy, m_done}, 32'd0);
        chk("abort_data", 32'(m_data), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_no_done", 32'(m_done), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_idle", {30'd0, m_busy, m_done}, 32'd0);
        setup_and_start(vecs[1]);
        wait_done(vecs[1]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
